// File: rtl/pc_sequencer_pkg.sv
//==============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared widths, FSM state encodings and next-PC select codes
//               for the program-counter sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam int c_PC_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t FETCH  = 2'd0;
    localparam state_t EXEC   = 2'd1;
    localparam state_t HALTED = 2'd2;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_TRAP   = 2'd3
    } next_sel_e;

    localparam logic [c_PC_W-1:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_mux.sv
//==============================================================================
// Module      : next_pc_mux
// Description : Priority next-PC select (trap > jump > branch > sequential)
//               and the PC incrementer. Macro PC_ALIGN_CHECK_EN turns a
//               misaligned redirect into a trap instead of masking it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter logic [31:0] PC_INC      = 32'd4
) (
    input  logic [31:0] pc,
    input  logic        trap_en,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic [1:0]  sel,
    output logic        misalign
);

    next_sel_e   w_sel;
    logic [31:0] w_target;

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc + PC_INC;
    assign sel      = w_sel;

    always_comb begin
        w_sel    = SEL_SEQ;
        w_target = pc_plus4;
        if (trap_en) begin
            w_sel    = SEL_TRAP;
            w_target = TRAP_VECTOR;
        end else if (jump_en) begin
            w_sel    = SEL_JUMP;
            w_target = jump_target;
        end else if (branch_taken) begin
            w_sel    = SEL_BRANCH;
            w_target = branch_target;
        end
    end

    always_comb begin
        next_pc  = w_target;
        misalign = 1'b0;
        if (w_sel == SEL_JUMP || w_sel == SEL_BRANCH) begin
`ifdef PC_ALIGN_CHECK_EN
            if (is_misaligned(w_target[1:0])) begin
                next_pc  = TRAP_VECTOR;
                misalign = 1'b1;
            end
`else
            next_pc = w_target & c_ALIGN_MASK;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//==============================================================================
// Module      : pc_sequencer
// Description : Program-counter controller: FETCH/EXEC/HALTED sequencing,
//               PC register and retired-instruction counter.
//               Optional macro: PC_ALIGN_CHECK_EN (misaligned redirect traps).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] PC_INC       = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        trap_en,
    input  logic        halt,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] instret,
    output logic        misalign
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_misalign;

    logic [31:0] w_next_pc;
    logic [1:0]  w_sel;
    logic        w_misalign;
    logic        w_enter_halt;

    next_pc_mux #(
        .TRAP_VECTOR (TRAP_VECTOR),
        .PC_INC      (PC_INC)
    ) u_next_pc_mux (
        .pc            (r_pc),
        .trap_en       (trap_en),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (w_next_pc),
        .sel           (w_sel),
        .misalign      (w_misalign)
    );

    // A pending trap overrides halt; a misaligned redirect is not a trap request.
    assign w_enter_halt = halt && (w_sel != SEL_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_VECTOR;
            r_instret  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        r_pc       <= w_next_pc;
                        r_instret  <= r_instret + 32'd1;
                        r_misalign <= w_misalign;
                        r_state    <= w_enter_halt ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr_valid = (r_state == EXEC);
    assign halted      = (r_state == HALTED);
    assign instret     = r_instret;
    assign misalign    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//==============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer with an instruction-level
//               reference model. Honours PC_ALIGN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        trap_en = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic [31:0] instret;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instret;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .trap_en       (trap_en),
        .halt          (halt),
        .resume        (resume),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .instret       (instret),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump_en = 0; trap_en = 0;
        halt = 0; resume = 0; branch_target = 0; jump_target = 0;
    endtask

    task automatic noise_inputs(input logic allow_resume);
        stall = 1'($urandom); branch_taken = 1'($urandom);
        jump_en = 1'($urandom); trap_en = 1'($urandom); halt = 1'($urandom);
        branch_target = $urandom; jump_target = $urandom;
        resume = allow_resume ? 1'($urandom) : 1'b0;
    endtask

    // Instruction-level reference: where the PC goes when EXEC retires.
    task automatic model_next(input logic t, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt,
                              output logic [31:0] npc, output logic mis);
        logic [31:0] tgt;
        mis = 1'b0;
        if (t) begin
            npc = c_TRAP_VECTOR;
        end else if (j || b) begin
            tgt = j ? jt : bt;
`ifdef PC_ALIGN_CHECK_EN
            if (tgt % 4 != 0) begin
                npc = c_TRAP_VECTOR;
                mis = 1'b1;
            end else begin
                npc = tgt;
            end
`else
            npc = tgt - (tgt % 4);
`endif
        end else begin
            npc = exp_pc + 32'd4;
        end
    endtask

    // Fetch phase: stray control inputs must be ignored while waiting.
    task automatic step_fetch(input int delay);
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_out !== exp_pc ||
                instr_valid !== 1'b0 || halted !== 1'b0 ||
                pc_plus4 !== exp_pc + 32'd4 || (i > 0 && misalign !== 1'b0)) begin
                failures++;
                $display("FAIL fetch req=%b addr=%h pc=%h p4=%h valid=%b halted=%b mis=%b expected req=1 addr=%h",
                         imem_req, imem_addr, pc_out, pc_plus4, instr_valid, halted, misalign, exp_pc);
            end
            noise_inputs(1'b1);
            imem_ready = (i == delay);
            @(negedge clk);
        end
        imem_ready = 0;
        clear_inputs();
    endtask

    task automatic step_exec(input int n_stall, input logic t, input logic j,
                             input logic [31:0] jt, input logic b,
                             input logic [31:0] bt, input logic h);
        logic [31:0] npc;
        logic        mis;
        logic        exp_halt;
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== exp_pc || instret !== exp_instret ||
            imem_req !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL exec_entry valid=%b pc=%h instret=%0d req=%b mis=%b expected valid=1 pc=%h instret=%0d",
                     instr_valid, pc_out, instret, imem_req, misalign, exp_pc, exp_instret);
        end
        for (int i = 0; i < n_stall; i++) begin
            noise_inputs(1'b1);
            stall = 1'b1;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== exp_pc || instret !== exp_instret) begin
                failures++;
                $display("FAIL stall valid=%b pc=%h instret=%0d expected valid=1 pc=%h instret=%0d",
                         instr_valid, pc_out, instret, exp_pc, exp_instret);
            end
        end
        clear_inputs();
        trap_en = t; jump_en = j; jump_target = jt;
        branch_taken = b; branch_target = bt; halt = h;
        @(negedge clk);
        clear_inputs();
        model_next(t, j, jt, b, bt, npc, mis);
        exp_pc = npc;
        exp_instret = exp_instret + 32'd1;
        exp_halt = h && !t;
        checks++;
        if (pc_out !== exp_pc || instret !== exp_instret || halted !== exp_halt ||
            imem_req !== !exp_halt || instr_valid !== 1'b0 || misalign !== mis) begin
            failures++;
            $display("FAIL retire pc=%h instret=%0d halted=%b req=%b valid=%b mis=%b expected pc=%h instret=%0d halted=%b mis=%b",
                     pc_out, instret, halted, imem_req, instr_valid, misalign,
                     exp_pc, exp_instret, exp_halt, mis);
        end
    endtask

    task automatic step_halted(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc_out !== exp_pc ||
                instret !== exp_instret || instr_valid !== 1'b0 ||
                (i > 0 && misalign !== 1'b0)) begin
                failures++;
                $display("FAIL halted halted=%b req=%b pc=%h instret=%0d mis=%b expected halted=1 req=0 pc=%h instret=%0d",
                         halted, imem_req, pc_out, instret, misalign, exp_pc, exp_instret);
            end
            noise_inputs(1'b0);
            imem_ready = 1'($urandom);
            @(negedge clk);
        end
        clear_inputs();
        imem_ready = 0;
        resume = 1;
        @(negedge clk);
        resume = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        noise_inputs(1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        clear_inputs();
        exp_pc = c_RESET_VECTOR;
        exp_instret = 0;
        checks++;
        if (pc_out !== c_RESET_VECTOR || instret !== 32'd0 || imem_req !== 1'b1 ||
            instr_valid !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset pc=%h instret=%0d req=%b valid=%b halted=%b mis=%b expected pc=0 instret=0 req=1",
                     pc_out, instret, imem_req, instr_valid, halted, misalign);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            step_fetch(0);
            step_exec(0, 0, 0, 0, 0, 0, 0);
        end
        checks++;
        if (instret !== 32'd3 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL seq_count instret=%0d addr=%h expected instret=3 addr=0000000c", instret, imem_addr);
        end
    endtask

    task automatic test_redirect_priority();
        step_fetch(1);
        step_exec(0, 0, 0, 0, 0, 0, 0);            // now at 0x10
        step_fetch(0);
        step_exec(0, 0, 1, 32'h200, 1, 32'h300, 0);
        step_fetch(2);
        step_exec(0, 1, 1, 32'h200, 1, 32'h300, 0);
        step_fetch(0);
        step_exec(0, 0, 0, 0, 1, 32'h300, 0);
    endtask

    task automatic test_stall();
        test_reset();
        step_fetch(0); step_exec(0, 0, 0, 0, 0, 0, 0);
        step_fetch(0); step_exec(0, 0, 0, 0, 0, 0, 0);
        step_fetch(0);
        step_exec(3, 0, 0, 0, 0, 0, 0);            // stalls at 0x8, retires to 0xC
    endtask

    task automatic test_halt_resume();
        step_fetch(0);
        step_exec(0, 0, 1, 32'h20, 0, 0, 0);
        step_fetch(0);
        step_exec(1, 0, 0, 0, 0, 0, 1);            // halts with pc 0x24
        step_halted(5);
        step_fetch(0);
        step_exec(0, 1, 0, 0, 0, 0, 1);            // trap wins over halt
    endtask

    task automatic test_wrap_and_midfetch_reset();
        step_fetch(0);
        step_exec(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step_fetch(0);
        step_exec(0, 0, 0, 0, 0, 0, 0);            // wraps to 0
        for (int i = 0; i < 3; i++) begin
            imem_ready = 0;
            noise_inputs(1'b1);
            @(negedge clk);
        end
        test_reset();
    endtask

    task automatic test_misalign();
        step_fetch(0);
        step_exec(0, 0, 1, 32'h202, 0, 0, 0);
        step_fetch(0);
        step_exec(0, 0, 0, 0, 1, 32'h0000_0413, 0);
        step_fetch(0);
    endtask

    task automatic test_random();
        logic        t, j, b, h;
        logic [31:0] jt, bt;
        for (int k = 0; k < 60; k++) begin
            step_fetch($urandom_range(0, 2));
            t  = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 6) == 0);
            jt = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            step_exec($urandom_range(0, 2), t, j, jt, b, bt, h);
            if (h && !t) step_halted($urandom_range(1, 3));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_redirect_priority();
        test_stall();
        test_halt_resume();
        test_wrap_and_midfetch_reset();
        test_misalign();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
